// File: rtl/multicycle_calc.sv
// multicycle_calc: operand-muxed ALU with single-cycle ops and an optional
// iterative shift-add multiplier. Define CALC_MUL_EN to build the multiplier;
// without it opcode 111 completes in one cycle with a zero result.
module multicycle_calc #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             input_start,
    input  logic [WIDTH-1:0] input_A,
    input  logic [WIDTH-1:0] input_B,
    input  logic [WIDTH-1:0] input_PC,
    input  logic [WIDTH-1:0] input_imm,
    input  logic [1:0]       input_ALUSrcA,
    input  logic [1:0]       input_ALUSrcB,
    input  logic [2:0]       input_ALUOp,
    output logic [WIDTH-1:0] output_ALU,
    output logic             output_Zero,
    output logic             output_negative,
    output logic             output_overflow,
    output logic             output_busy,
    output logic             output_done
);

    localparam int unsigned MSB = WIDTH - 1;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] add_c;
    logic [WIDTH-1:0] sub_c;
    logic [WIDTH-1:0] res_c;
    logic             ovf_c;
    logic             slt_c;

    // Operand selection from the current inputs
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (input_ALUSrcA)
            2'b00:   op_a = input_A;
            2'b01:   op_a = input_PC;
            default: op_a = '0;
        endcase
        case (input_ALUSrcB)
            2'b00:   op_b = input_B;
            2'b01:   op_b = input_imm;
            2'b10:   op_b = WIDTH'(2);
            default: op_b = {input_imm[WIDTH-2:0], 1'b0};
        endcase
    end

    // Single-cycle result and overflow flag
    always_comb begin
        add_c = op_a + op_b;
        sub_c = op_a - op_b;
        slt_c = ($signed(op_a) < $signed(op_b));
        res_c = '0;
        ovf_c = 1'b0;
        case (input_ALUOp)
            3'b000: res_c = op_a;
            3'b001: begin
                res_c = add_c;
                ovf_c = (op_a[MSB] == op_b[MSB]) && (add_c[MSB] != op_a[MSB]);
            end
            3'b010: begin
                res_c = sub_c;
                ovf_c = (op_a[MSB] != op_b[MSB]) && (sub_c[MSB] != op_a[MSB]);
            end
            3'b011: res_c = op_a & op_b;
            3'b100: res_c = op_a | op_b;
            3'b101: res_c = op_a ^ op_b;
            3'b110: res_c = {{(WIDTH-1){1'b0}}, slt_c};
            default: res_c = '0;
        endcase
    end

`ifdef CALC_MUL_EN
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [PW-1:0]    acc_next;

    // One shift-add step; on the last step this is the full product
    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    // Control FSM, multiplier datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            acc             <= '0;
            mcand           <= '0;
            mplier          <= '0;
            output_ALU      <= '0;
            output_Zero     <= 1'b0;
            output_negative <= 1'b0;
            output_overflow <= 1'b0;
            output_busy     <= 1'b0;
            output_done     <= 1'b0;
        end else begin
            output_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (input_start) begin
                        if (input_ALUOp == 3'b111) begin
                            state       <= MUL;
                            output_busy <= 1'b1;
                            cnt         <= '0;
                            acc         <= '0;
                            mcand       <= {{WIDTH{1'b0}}, op_a};
                            mplier      <= op_b;
                        end else begin
                            output_ALU      <= res_c;
                            output_Zero     <= (res_c == '0);
                            output_negative <= res_c[MSB];
                            output_overflow <= ovf_c;
                            output_done     <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    if (cnt == CW'(WIDTH - 1)) begin
                        output_ALU      <= acc_next[WIDTH-1:0];
                        output_Zero     <= (acc_next[WIDTH-1:0] == '0);
                        output_negative <= acc_next[MSB];
                        output_overflow <= |acc_next[PW-1:WIDTH];
                        output_done     <= 1'b1;
                        output_busy     <= 1'b0;
                        cnt             <= '0;
                        state           <= IDLE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= {mcand[PW-2:0], 1'b0};
                        mplier <= {1'b0, mplier[WIDTH-1:1]};
                        cnt    <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    // Without the multiplier every op completes at the accepting edge
    assign output_busy = 1'b0;

    // Registered result and flags, updated on each accepted start
    always_ff @(posedge clk) begin
        if (reset) begin
            output_ALU      <= '0;
            output_Zero     <= 1'b0;
            output_negative <= 1'b0;
            output_overflow <= 1'b0;
            output_done     <= 1'b0;
        end else begin
            output_done <= 1'b0;
            if (input_start) begin
                output_ALU      <= res_c;
                output_Zero     <= (res_c == '0);
                output_negative <= res_c[MSB];
                output_overflow <= ovf_c;
                output_done     <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_calc.sv
// Self-checking bench for multicycle_calc (WIDTH=16). Honours CALC_MUL_EN.
module tb_multicycle_calc;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a, b, pc, imm;
    logic [1:0]  srca, srcb;
    logic [2:0]  op;
    logic [15:0] alu;
    logic        zero, neg, ovf, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    multicycle_calc #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .input_start(start),
        .input_A(a), .input_B(b), .input_PC(pc), .input_imm(imm),
        .input_ALUSrcA(srca), .input_ALUSrcB(srcb), .input_ALUOp(op),
        .output_ALU(alu), .output_Zero(zero), .output_negative(neg),
        .output_overflow(ovf), .output_busy(busy), .output_done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  srca, srcb;
        logic [2:0]  op;
        logic [15:0] a, b, pc, imm;
        logic [15:0] alu;
        logic        z, n, v;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: spec rules in plain integer arithmetic
    function automatic void model(input logic [1:0] sa_sel, input logic [1:0] sb_sel,
                                  input logic [2:0] opc, input logic [15:0] ra,
                                  input logic [15:0] rb, input logic [15:0] rpc,
                                  input logic [15:0] rimm, output logic [15:0] r,
                                  output logic z, output logic n, output logic v);
        int ia, ib, sa, sb, s, ri;
        longint p;
        ia = (sa_sel == 2'd0) ? int'(ra) : (sa_sel == 2'd1) ? int'(rpc) : 0;
        case (sb_sel)
            2'd0:    ib = int'(rb);
            2'd1:    ib = int'(rimm);
            2'd2:    ib = 2;
            default: ib = (int'(rimm) * 2) % 65536;
        endcase
        sa = (ia >= 32768) ? ia - 65536 : ia;
        sb = (ib >= 32768) ? ib - 65536 : ib;
        v = 1'b0;
        ri = 0;
        case (opc)
            3'd0: ri = ia;
            3'd1: begin s = sa + sb; ri = (ia + ib) & 32'hFFFF; v = (s > 32767) || (s < -32768); end
            3'd2: begin s = sa - sb; ri = (ia - ib) & 32'hFFFF; v = (s > 32767) || (s < -32768); end
            3'd3: ri = ia & ib;
            3'd4: ri = ia | ib;
            3'd5: ri = ia ^ ib;
            3'd6: ri = (sa < sb) ? 1 : 0;
            default: begin
`ifdef CALC_MUL_EN
                p  = longint'(ia) * longint'(ib);
                ri = int'(p % 65536);
                v  = (p >= 65536);
`else
                p  = 0;
                ri = int'(p);
`endif
            end
        endcase
        r = 16'(ri);
        z = (ri == 0);
        n = r[15];
    endfunction

    task automatic drive(input logic [1:0] sa_sel, input logic [1:0] sb_sel, input logic [2:0] opc,
                         input logic [15:0] ra, input logic [15:0] rb,
                         input logic [15:0] rpc, input logic [15:0] rimm);
        srca = sa_sel; srcb = sb_sel; op = opc; a = ra; b = rb; pc = rpc; imm = rimm;
        start = 1'b1;
    endtask

    // Accept at the next edge, scramble inputs, check result one cycle later
    task automatic run_single(input string name, input logic [15:0] ealu,
                              input logic ez, input logic en, input logic ev);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF; imm = 16'h5A5A; pc = 16'h0F0F;
        chk({name, " done"}, 32'(done), 32'd1);
        chk({name, " busy"}, 32'(busy), 32'd0);
        chk({name, " alu"}, 32'(alu), 32'(ealu));
        chk({name, " flags"}, {29'd0, zero, neg, ovf}, {29'd0, ez, en, ev});
    endtask

`ifdef CALC_MUL_EN
    // Launch a MUL, optionally poke an ignored start while busy, count busy cycles
    task automatic run_mul(input string name, input logic poke, input logic [15:0] ealu,
                           input logic ez, input logic ev);
        int cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'hDEAD; b = 16'hBEEF;
        chk({name, " busy start"}, 32'(busy), 32'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (poke && cyc == 3) begin a = 16'h0002; op = 3'b111; start = 1'b1; end
            else start = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        chk({name, " cycles"}, 32'(cyc), 32'd16);
        chk({name, " alu"}, 32'(alu), 32'(ealu));
        chk({name, " flags"}, {30'd0, zero, ovf}, {30'd0, ez, ev});
        chk({name, " busy end"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk({name, " single done"}, 32'(done), 32'd0);
        chk({name, " hold"}, 32'(alu), 32'(ealu));
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] er;
        logic ez, en, ev;
        tbl[0]  = '{2'b00, 2'b00, 3'd1, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 16'h68AC, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{2'b00, 2'b01, 3'd2, 16'hABCD, 16'h0000, 16'h0000, 16'h1111, 16'h9ABC, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{2'b00, 2'b00, 3'd1, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 16'h8000, 1'b0, 1'b1, 1'b1};
        tbl[3]  = '{2'b01, 2'b10, 3'd1, 16'h1234, 16'h0000, 16'hABCD, 16'h0000, 16'hABCF, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{2'b00, 2'b00, 3'd2, 16'h8000, 16'h0001, 16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        tbl[5]  = '{2'b00, 2'b00, 3'd6, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{2'b00, 2'b00, 3'd6, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{2'b00, 2'b00, 3'd3, 16'hF0F0, 16'h3C3C, 16'h0000, 16'h0000, 16'h3030, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{2'b00, 2'b00, 3'd4, 16'hF0F0, 16'h0F0F, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{2'b00, 2'b00, 3'd5, 16'hAAAA, 16'hAAAA, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{2'b10, 2'b00, 3'd0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{2'b10, 2'b11, 3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h8001, 16'h0002, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{2'b00, 2'b00, 3'd0, 16'h8001, 16'h0000, 16'h0000, 16'h0000, 16'h8001, 1'b0, 1'b1, 1'b0};
        tbl[13] = '{2'b00, 2'b00, 3'd2, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b1, 1'b0};

        reset = 1'b1; start = 1'b0;
        a = '0; b = '0; pc = '0; imm = '0; srca = '0; srcb = '0; op = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outputs", {alu, zero, neg, ovf, busy, done}, 32'd0);
        reset = 1'b0;

        // Directed table, issued back-to-back with start held high
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].srca, tbl[i].srcb, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].pc, tbl[i].imm);
            run_single($sformatf("vec%0d", i), tbl[i].alu, tbl[i].z, tbl[i].n, tbl[i].v);
        end

        // Idle cycle: done drops, result holds
        @(posedge clk);
        #1;
        chk("idle done", 32'(done), 32'd0);
        chk("idle hold", 32'(alu), 32'h0000FFFF);

`ifdef CALC_MUL_EN
        drive(2'b00, 2'b00, 3'd7, 16'h00FF, 16'h0101, 16'h0, 16'h0);
        run_mul("mul ff", 1'b1, 16'hFFFF, 1'b0, 1'b0);
        drive(2'b00, 2'b00, 3'd7, 16'h0100, 16'h0100, 16'h0, 16'h0);
        run_mul("mul ovf", 1'b0, 16'h0000, 1'b1, 1'b1);

        // Reset five cycles into a MUL aborts it
        drive(2'b00, 2'b00, 3'd7, 16'h1234, 16'h5678, 16'h0, 16'h0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mul abort busy", 32'(busy), 32'd0);
        chk("mul abort outs", {alu, zero, neg, ovf, done}, 32'd0);
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) chk("mul abort no done", 32'(done), 32'd0);
        end
        drive(2'b00, 2'b00, 3'd1, 16'h0001, 16'h0001, 16'h0, 16'h0);
        run_single("add after abort", 16'h0002, 1'b0, 1'b0, 1'b0);
`else
        drive(2'b00, 2'b00, 3'd7, 16'h0003, 16'h0003, 16'h0, 16'h0);
        run_single("mul disabled", 16'h0000, 1'b1, 1'b0, 1'b0);
`endif

        // Start coincident with reset is dropped, not queued
        drive(2'b00, 2'b00, 3'd1, 16'h1111, 16'h2222, 16'h0, 16'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        chk("reset+start outs", {alu, zero, neg, ovf, busy, done}, 32'd0);
        @(posedge clk);
        #1;
        chk("reset+start no done", 32'(done), 32'd0);

        // Randomised ops against the reference model
        for (int i = 0; i < 150; i++) begin
            logic [1:0] rsa, rsb;
            logic [2:0] rop;
            logic [15:0] ra, rb, rpc, rimm;
            rsa = 2'($urandom_range(0, 3)); rsb = 2'($urandom_range(0, 3));
            rop = 3'($urandom_range(0, 7));
            ra = 16'($urandom); rb = 16'($urandom); rpc = 16'($urandom); rimm = 16'($urandom);
            if (i % 5 == 0) begin ra = 16'h7FFF; rb = 16'h8000; end
            model(rsa, rsb, rop, ra, rb, rpc, rimm, er, ez, en, ev);
            drive(rsa, rsb, rop, ra, rb, rpc, rimm);
`ifdef CALC_MUL_EN
            if (rop == 3'd7) run_mul($sformatf("rnd%0d", i), 1'b0, er, ez, ev);
            else run_single($sformatf("rnd%0d", i), er, ez, en, ev);
`else
            run_single($sformatf("rnd%0d", i), er, ez, en, ev);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
